// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants and state encoding for the MLP loader and the
// sequencing controller that reads the same memories.
package mlp_pkg;

  localparam int DW       = 8;
  localparam int N_IN     = 12;
  localparam int N_HID    = 64;
  localparam int N_OUT    = 4;
  localparam int L0_WORDS = N_HID * (N_IN + 1);   // 832
  localparam int L1_WORDS = N_OUT * (N_HID + 1);  // 260
  localparam int IB_AW    = 4;
  localparam int W_AW     = 12;

  localparam logic [DW-1:0] BIAS_ONE = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    LD_IN,
    BIAS,
    LD_W0,
    LD_W1,
    START,
    WAIT
  } state_t;

  // States in which the host may transfer a word.
  function automatic logic accepts(state_t s);
    return (s == IDLE) || (s == LD_IN) || (s == LD_W0) || (s == LD_W1);
  endfunction

endpackage

// File: rtl/mlp_loader_if.sv
// mlp_loader_if: bundles the host word stream, the controller handshake and
// the memory write ports of the loader.
//   master : the loader (drives in_ready, write strobes, start/busy/err)
//   slave  : host + controller + memories (drive the stream and compute_done)
interface mlp_loader_if;
  import mlp_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            skip_w;
  logic            compute_done;

  logic            ib_we;
  logic [IB_AW-1:0] ib_addr;
  logic [DW-1:0]   ib_data;
  logic            w0_we;
  logic            w1_we;
  logic [W_AW-1:0] w_addr;
  logic [DW-1:0]   w_data;

  logic            start;
  logic            busy;
  logic            err;

  modport master (
    input  in_valid, in_data, in_last, skip_w, compute_done,
    output in_ready, ib_we, ib_addr, ib_data, w0_we, w1_we, w_addr, w_data,
           start, busy, err
  );

  modport slave (
    output in_valid, in_data, in_last, skip_w, compute_done,
    input  in_ready, ib_we, ib_addr, ib_data, w0_we, w1_we, w_addr, w_data,
           start, busy, err
  );

endinterface

// File: rtl/mlp_wr_addr_gen.sv
// mlp_wr_addr_gen: input-buffer and weight write counters with terminal-count
// flags, plus the registered write strobes/address/data.
//   clk, rst          : clock, async active-high reset
//   state_i           : loader FSM state (selects target memory)
//   xfer_i, data_i    : accepted host word and its data
//   ib_tc_o           : current input word is the last input word
//   w0_tc_o, w1_tc_o  : current weight word is the last of its layer
//   ib_*_o, w*_o      : write ports, valid the cycle after the transfer
module mlp_wr_addr_gen
  import mlp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  state_t           state_i,
  input  logic             xfer_i,
  input  logic [DW-1:0]    data_i,
  output logic             ib_tc_o,
  output logic             w0_tc_o,
  output logic             w1_tc_o,
  output logic             ib_we_o,
  output logic [IB_AW-1:0] ib_addr_o,
  output logic [DW-1:0]    ib_data_o,
  output logic             w0_we_o,
  output logic             w1_we_o,
  output logic [W_AW-1:0]  w_addr_o,
  output logic [DW-1:0]    w_data_o
);

  logic [IB_AW-1:0] ib_cnt_q;
  logic [W_AW-1:0]  w_cnt_q;
  logic             ib_we_q, w0_we_q, w1_we_q;
  logic [IB_AW-1:0] ib_addr_q;
  logic [DW-1:0]    ib_data_q;
  logic [W_AW-1:0]  w_addr_q;
  logic [DW-1:0]    w_data_q;

  assign ib_tc_o = (ib_cnt_q == IB_AW'(N_IN - 1));
  assign w0_tc_o = (w_cnt_q == W_AW'(L0_WORDS - 1));
  assign w1_tc_o = (w_cnt_q == W_AW'(L1_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ib_cnt_q  <= '0;
      w_cnt_q   <= '0;
      ib_we_q   <= 1'b0;
      w0_we_q   <= 1'b0;
      w1_we_q   <= 1'b0;
      ib_addr_q <= '0;
      ib_data_q <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      ib_we_q <= 1'b0;
      w0_we_q <= 1'b0;
      w1_we_q <= 1'b0;
      case (state_i)
        IDLE: begin
          // Counters are re-armed here so an aborted frame leaves no residue.
          w_cnt_q  <= '0;
          ib_cnt_q <= '0;
          if (xfer_i) begin
            ib_we_q   <= 1'b1;
            ib_addr_q <= '0;
            ib_data_q <= data_i;
            ib_cnt_q  <= IB_AW'(1);
          end
        end
        LD_IN: begin
          if (xfer_i) begin
            ib_we_q   <= 1'b1;
            ib_addr_q <= ib_cnt_q;
            ib_data_q <= data_i;
            ib_cnt_q  <= ib_cnt_q + IB_AW'(1);
          end
        end
        BIAS: begin
          ib_we_q   <= 1'b1;
          ib_addr_q <= IB_AW'(N_IN);
          ib_data_q <= BIAS_ONE;
        end
        LD_W0: begin
          if (xfer_i) begin
            w0_we_q  <= 1'b1;
            w_addr_q <= w_cnt_q;
            w_data_q <= data_i;
            w_cnt_q  <= w0_tc_o ? '0 : w_cnt_q + W_AW'(1);
          end
        end
        LD_W1: begin
          if (xfer_i) begin
            w1_we_q  <= 1'b1;
            w_addr_q <= w_cnt_q;
            w_data_q <= data_i;
            w_cnt_q  <= w1_tc_o ? '0 : w_cnt_q + W_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ib_we_o   = ib_we_q;
  assign ib_addr_o = ib_addr_q;
  assign ib_data_o = ib_data_q;
  assign w0_we_o   = w0_we_q;
  assign w1_we_o   = w1_we_q;
  assign w_addr_o  = w_addr_q;
  assign w_data_o  = w_data_q;

endmodule

// File: rtl/mlp_loader.sv
// mlp_loader: write-side front end of the two-layer MLP. Fills the input
// buffer (plus bias slot) and both weight memories from a host word stream,
// pulses start, and holds the host off until compute_done.
//   clk, rst : clock, async active-high reset
//   bus      : mlp_loader_if.master (host stream, memory writes, start/busy/err)
module mlp_loader
  import mlp_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mlp_loader_if.master bus
);

  state_t state_q, state_d;
  logic   skip_q;
  logic   in_ready_q;
  logic   start_q;
  logic   busy_q;
  logic   err_q;
  logic   xfer;
  logic   frame_err;
  logic   ib_tc, w0_tc, w1_tc;

  assign xfer = bus.in_valid & in_ready_q;

  mlp_wr_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .state_i   (state_q),
    .xfer_i    (xfer),
    .data_i    (bus.in_data),
    .ib_tc_o   (ib_tc),
    .w0_tc_o   (w0_tc),
    .w1_tc_o   (w1_tc),
    .ib_we_o   (bus.ib_we),
    .ib_addr_o (bus.ib_addr),
    .ib_data_o (bus.ib_data),
    .w0_we_o   (bus.w0_we),
    .w1_we_o   (bus.w1_we),
    .w_addr_o  (bus.w_addr),
    .w_data_o  (bus.w_data)
  );

  // in_last must coincide exactly with the final word of the frame; anything
  // else aborts to IDLE with err set. The offending word is still written.
  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (bus.in_last) frame_err = 1'b1;
          else             state_d   = LD_IN;
        end
      end
      LD_IN: begin
        if (xfer) begin
          if (ib_tc) begin
            // skip_w frames end on the last input word; full frames must not.
            if (bus.in_last == skip_q) state_d   = BIAS;
            else                       frame_err = 1'b1;
          end else if (bus.in_last) begin
            frame_err = 1'b1;
          end
        end
      end
      BIAS:  state_d = skip_q ? START : LD_W0;
      LD_W0: begin
        if (xfer) begin
          if (bus.in_last) frame_err = 1'b1;
          else if (w0_tc)  state_d   = LD_W1;
        end
      end
      LD_W1: begin
        if (xfer) begin
          if (w1_tc) begin
            if (bus.in_last) state_d   = START;
            else             frame_err = 1'b1;
          end else if (bus.in_last) begin
            frame_err = 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT:  if (bus.compute_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frame_err) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      skip_q     <= 1'b0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= accepts(state_d);
      // Delayed by one cycle so start follows the final write strobe.
      start_q    <= (state_q == START);
      if (state_q == IDLE && xfer) begin
        skip_q <= bus.skip_w;
        busy_q <= 1'b1;
        err_q  <= 1'b0;
      end
      if (state_q == WAIT && bus.compute_done) busy_q <= 1'b0;
      if (frame_err) begin
        err_q  <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.start    = start_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule
